// File: rtl/ysyx_040750_onehot_dispatch.sv
// Purpose: buffered 1-to-M demux; beats carry a one-hot destination and leave in strict order.
// Latency: 1 cycle push-to-output (registered FIFO head, no fall-through).
// Backpressure: O_ready registered from next-cycle occupancy; head stalls until its own I_ready bit.
//
// Ports:
//   I_clk / I_rst_n        clock, asynchronous active-low reset
//   I_valid/O_ready/I_data/I_sel   producer side, I_sel one-hot destination
//   O_valid/I_ready/O_data         consumer side, O_valid per destination, data broadcast
//   O_err / O_err_cnt      one-cycle drop pulse, saturating 8-bit drop count

// Purpose: generic DEPTH-entry FIFO with occupancy-based full/empty and cleared storage.
// Latency: 1 cycle write-to-read; read data is 0 while empty.
// Backpressure: nfull_o is registered from next occupancy; caller must not push when it is low.
module ysyx_040750_onehot_dispatch_fifo #(
    parameter int W     = 68,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] wdat_i,
    input  logic         pop_i,
    output logic [W-1:0] rdat_o,
    output logic         nfull_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          nfull_q;

    // Occupancy, not pointer equality, decides full/empty so pointers can wrap freely.
    always_comb begin
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            nfull_q <= 1'b0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= wdat_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + AW'(1);
            end
            cnt_q   <= cnt_d;
            // Registered ready: a pop while full only reopens the input one cycle later.
            nfull_q <= (cnt_d < CW'(DEPTH));
        end
    end

    assign rdat_o  = (cnt_q != '0) ? mem_q[rptr_q] : '0;
    assign nfull_o = nfull_q;
endmodule

module ysyx_040750_onehot_dispatch #(
    parameter int N     = 64,
    parameter int M     = 4,
    parameter int DEPTH = 2
) (
    input  logic         I_clk,
    input  logic         I_rst_n,
    input  logic         I_valid,
    output logic         O_ready,
    input  logic [N-1:0] I_data,
    input  logic [M-1:0] I_sel,
    output logic [M-1:0] O_valid,
    input  logic [M-1:0] I_ready,
    output logic [N-1:0] O_data,
    output logic         O_err,
    output logic [7:0]   O_err_cnt
);
    logic           push;
    logic           sel_legal;
    logic           push_legal;
    logic           pop;
    logic [N+M-1:0] head;
    logic           err_q;
    logic [7:0]     err_cnt_q;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign sel_legal  = (I_sel != '0) && ((I_sel & (I_sel - M'(1))) == '0);
    assign push       = I_valid && O_ready;
    assign push_legal = push && sel_legal;

    // Head sel is all-zero while empty, so an empty FIFO never pops.
    assign pop = |(O_valid & I_ready);

    ysyx_040750_onehot_dispatch_fifo #(
        .W     (N + M),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (I_clk),
        .rst_n_i (I_rst_n),
        .push_i  (push_legal),
        .wdat_i  ({I_data, I_sel}),
        .pop_i   (pop),
        .rdat_o  (head),
        .nfull_o (O_ready)
    );

    assign O_data  = head[N+M-1:M];
    assign O_valid = head[M-1:0];

    // Illegal beats are accepted (to keep the producer moving) but never stored.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= push && !sel_legal;
            if (push && !sel_legal && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign O_err     = err_q;
    assign O_err_cnt = err_cnt_q;
endmodule
